// File: rtl/bus_sched_if.sv
// Bus scheduler signal bundle: CPU/DMA/halt requests in, phase clock, grants and memory strobes out.
// Latency: none (wires only).
// Backpressure: none; requests are levels sampled by the scheduler at clk_in edges.
//
// Signals:
//   cpu_rw   - CPU read(1)/write(0)
//   dma_req  - secondary requester bus request (level)
//   dma_we   - DMA write(1)/read(0)
//   halt_req - hold the CPU with phi2 low (level)
//   phi2     - CPU phase-2 clock
//   cpu_sel  - CPU owns the memory bus
//   dma_gnt  - DMA owns the memory bus
//   halted   - CPU is being held
//   mem_oe_n - memory output enable, active-low
//   mem_we_n - memory write enable, active-low
interface bus_sched_if;
    logic cpu_rw;
    logic dma_req;
    logic dma_we;
    logic halt_req;
    logic phi2;
    logic cpu_sel;
    logic dma_gnt;
    logic halted;
    logic mem_oe_n;
    logic mem_we_n;

    // Requester side (CPU glue, DMA engine, halt source).
    modport master (
        output cpu_rw, dma_req, dma_we, halt_req,
        input  phi2, cpu_sel, dma_gnt, halted, mem_oe_n, mem_we_n
    );

    // Scheduler side.
    modport slave (
        input  cpu_rw, dma_req, dma_we, halt_req,
        output phi2, cpu_sel, dma_gnt, halted, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/bus_sched.sv
// Memory bus scheduler: generates phi2 and time-slices the bus between CPU (phi2 high) and DMA (phi2 low / halt).
// Latency: every output is registered; requests seen at an edge affect outputs on that same edge.
// Backpressure: a DMA request waits for the next PH2->PH1 boundary or HALT; halt is honoured only at PH1 end.
//
// Ports: clk_in (system clock), reset (synchronous, active-low), bus (bus_sched_if.slave).
// Parameter DIV: clk_in cycles per phi2 half-phase, 3..15.
module bus_sched #(
    parameter int unsigned DIV = 6
) (
    input  logic       clk_in,
    input  logic       reset,
    bus_sched_if.slave bus
);

    typedef enum logic [1:0] {
        PH1  = 2'd0,
        PH2  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] LAST   = 4'(DIV - 1);
    localparam logic [3:0] WE_END = 4'(DIV - 2);

    state_t     state, state_nxt;
    logic [3:0] count, count_nxt;
    logic       phi2_q, cpu_sel_q, dma_gnt_q, halted_q, oe_n_q, we_n_q;
    logic       gnt_nxt, halted_nxt, oe_nxt, we_nxt;
    logic       cpu_rw_l, rw_nxt;
    logic       dma_we_l, we_l_nxt;
    logic       phase_end, strobe_win;

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        gnt_nxt    = dma_gnt_q;
        halted_nxt = halted_q;
        rw_nxt     = cpu_rw_l;
        we_l_nxt   = dma_we_l;
        oe_nxt     = 1'b1;
        we_nxt     = 1'b1;
        phase_end  = (count == LAST);

        unique case (state)
            PH1: begin
                if (phase_end) begin
                    count_nxt = 4'd0;
                    if (bus.halt_req) begin
                        state_nxt  = HALT;
                        halted_nxt = 1'b1;
                        gnt_nxt    = bus.dma_req;
                    end else begin
                        state_nxt = PH2;
                        gnt_nxt   = 1'b0;
                        rw_nxt    = bus.cpu_rw;
                    end
                end else begin
                    count_nxt = count + 4'd1;
                end
            end
            PH2: begin
                // The CPU half-phase always runs to completion; halt is only considered at PH1 end.
                if (phase_end) begin
                    count_nxt = 4'd0;
                    state_nxt = PH1;
                    gnt_nxt   = bus.dma_req;
                end else begin
                    count_nxt = count + 4'd1;
                end
            end
            HALT: begin
                count_nxt = 4'd0;
                if (!bus.halt_req) begin
                    state_nxt  = PH1;
                    halted_nxt = 1'b0;
                    gnt_nxt    = 1'b0;
                end else begin
                    // Grant tracks the request, but stays one extra cycle after an
                    // active write strobe so address/data are held past mem_we_n rising.
                    gnt_nxt = bus.dma_req | (dma_gnt_q & ~we_n_q);
                end
            end
            default: begin
                state_nxt = PH1;
                count_nxt = 4'd0;
            end
        endcase

        // DMA direction is captured once, when the grant is newly given.
        if (gnt_nxt && !dma_gnt_q) begin
            we_l_nxt = bus.dma_we;
        end

        // Timed write window: skip first and last cycle of a half-phase for setup/hold.
        strobe_win = (count_nxt >= 4'd1) && (count_nxt <= WE_END);

        if (state_nxt == PH2) begin
            if (rw_nxt) begin
                oe_nxt = 1'b0;
            end else if (strobe_win) begin
                we_nxt = 1'b0;
            end
        end else if (gnt_nxt) begin
            if (!we_l_nxt) begin
                oe_nxt = 1'b0;
            end else if (state_nxt == PH1) begin
                if (strobe_win) begin
                    we_nxt = 1'b0;
                end
            end else if (state == HALT && dma_gnt_q && bus.dma_req) begin
                // Untimed halt write: strobe starts one cycle after the grant and
                // ends on the edge that sees the request withdrawn.
                we_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state     <= PH1;
            count     <= 4'd0;
            phi2_q    <= 1'b0;
            cpu_sel_q <= 1'b0;
            dma_gnt_q <= 1'b0;
            halted_q  <= 1'b0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            cpu_rw_l  <= 1'b1;
            dma_we_l  <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            // phi2 and cpu_sel are separate flops with the same D so each output is clean.
            phi2_q    <= (state_nxt == PH2);
            cpu_sel_q <= (state_nxt == PH2);
            dma_gnt_q <= gnt_nxt;
            halted_q  <= halted_nxt;
            oe_n_q    <= oe_nxt;
            we_n_q    <= we_nxt;
            cpu_rw_l  <= rw_nxt;
            dma_we_l  <= we_l_nxt;
        end
    end

    assign bus.phi2     = phi2_q;
    assign bus.cpu_sel  = cpu_sel_q;
    assign bus.dma_gnt  = dma_gnt_q;
    assign bus.halted   = halted_q;
    assign bus.mem_oe_n = oe_n_q;
    assign bus.mem_we_n = we_n_q;

endmodule

// File: doc/bus_sched.md
BUS_SCHED -- requirements
Module: bus_sched

Interface
REQ-001 Parameter DIV, default 6, clk_in cycles per phi2 half-phase; legal range 3..15.
REQ-002 reset  input  1  synchronous, active-low reset.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 phi2  output  1  CPU phase-2 clock, registered.
REQ-005 cpu_sel  output  1  CPU owns memory bus; high exactly while phi2 high.
REQ-006 cpu_rw  input  1  CPU read(1)/write(0).
REQ-007 dma_req  input  1  secondary requester (loader/DMA) bus request, level.
REQ-008 dma_we  input  1  DMA write(1)/read(0).
REQ-009 dma_gnt  output  1  DMA owns memory bus, registered.
REQ-010 halt_req  input  1  request to hold CPU with phi2 low, level.
REQ-011 halted  output  1  CPU is held, registered.
REQ-012 mem_oe_n  output  1  memory output enable, active-low, registered.
REQ-013 mem_we_n  output  1  memory write enable, active-low, registered.

Function
REQ-014 State machine SHALL have states PH1 (phi2=0), PH2 (phi2=1) and HALT (phi2=0).
REQ-015 A 4-bit phase counter SHALL count 0..DIV-1 in PH1 and PH2; at count==DIV-1 it SHALL return to 0 and the state SHALL change on the same edge.
REQ-016 PH1 end (count==DIV-1): halt_req=0 -> PH2; halt_req=1 -> HALT with halted=1 on that edge.
REQ-017 PH2 end SHALL always go to PH1; halt is never entered from PH2, so the CPU cycle in progress always completes.
REQ-018 Unhalted phi2 period SHALL be 2*DIV clk_in cycles at 50% duty.
REQ-019 HALT SHALL hold the counter at 0; on the first edge with halt_req=0 it SHALL go to PH1 with count=0, halted=0, giving a full DIV-cycle phi2 low time before the next rise.
REQ-020 At the PH2->PH1 edge dma_gnt SHALL load dma_req; dma_gnt SHALL then hold for the whole PH1 half-phase.
REQ-021 At PH1->PH2, dma_gnt SHALL clear.
REQ-022 At PH1->HALT, dma_gnt SHALL load dma_req.
REQ-023 In HALT, dma_gnt SHALL load dma_req every cycle.
REQ-024 At HALT->PH1, dma_gnt SHALL clear.
REQ-025 dma_req rising mid-PH1 SHALL NOT be granted until the next PH2->PH1 edge or HALT.
REQ-026 cpu_sel and dma_gnt SHALL never be high together.
REQ-027 cpu_rw SHALL be latched at the PH1->PH2 edge; dma_we SHALL be latched when dma_gnt is set.
REQ-028 Read: mem_oe_n SHALL be low for the full owner half-phase (PH2 when latched cpu_rw=1; granted PH1/HALT when latched dma_we=0); else high.
REQ-029 Write, PH1/PH2 owner: mem_we_n SHALL be low from the 2nd through the (DIV-1)th cycle of the half-phase (counter 1..DIV-2), DIV-2 cycles; high on the first and last cycle for address/data setup and hold.
REQ-030 Write, HALT: mem_we_n SHALL go low one cycle after dma_gnt rises and rise on the edge dma_req falls; dma_gnt SHALL drop one cycle later.
REQ-031 mem_oe_n and mem_we_n SHALL never be low simultaneously.
REQ-032 halt_req and dma_req changing on the same edge as a phase boundary SHALL be sampled at that edge (the value present before the edge).

Reset
REQ-033 While reset=0: state=PH1, count=0, phi2=0, cpu_sel=0, dma_gnt=0, halted=0, mem_oe_n=1, mem_we_n=1.
REQ-034 After reset release, phi2 SHALL first rise on the DIV-th rising edge of clk_in with reset=1.
REQ-035 Reset asserted mid-phase, mid-write or in HALT SHALL abort immediately at the next edge; mem_we_n=1 on that edge.

Verification
REQ-036 DIV=6, no requests: phi2 high 6 / low 6 cycles repeating; first rise on 6th edge after release; mem_oe_n low during PH2 with cpu_rw=1.
REQ-037 DIV=6, dma_req=1 held, dma_we=1: dma_gnt high every PH1 (6 cycles); mem_we_n low 4 cycles per slot; never overlaps cpu_sel.
REQ-038 halt_req pulsed in PH2: CPU completes PH2; halted=1 at next PH1 end; phi2 stays 0; after release, phi2 low exactly 6 cycles before rising.
REQ-039 HALT with dma_req toggling 1/0: dma_gnt follows with 1-cycle lag; mem_we_n never low while dma_gnt=0.
REQ-040 reset=0 during DMA write in HALT: next edge mem_we_n=1, dma_gnt=0, halted=0, phi2=0.
REQ-041 DIV=3 sweep: period 6; mem_we_n write window 1 cycle; cpu_sel/dma_gnt exclusivity holds.
